oai211_bist_ctrl: RTL



---
 rtl/oai211_bist_pkg.sv | 21 ++
 rtl/oai211_bist_misr.sv | 35 +++
 rtl/oai211_bist_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/oai211_bist_pkg.sv
// Shared types and constants for the oai211 BIST sequencer.
package oai211_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int          VEC_N     = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Reference oai211 function for vector {A1,A2,B,C}
  function automatic logic oai211_golden(input logic [3:0] vec);
    return ~((vec[3] | vec[2]) & vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/oai211_bist_misr.sv
// 16-bit MISR compacting the sampled ZN stream; clear loads the seed.
module oai211_bist_misr
  import oai211_bist_pkg::*;
(
  input  logic        CLK,
  input  logic        RN,
  input  logic        en,
  input  logic        clr,
  input  logic        din,
  output logic [15:0] sig
);

  logic [15:0] sig_q, sig_d;
  logic        fb;

  // Next MISR value: seed on clear, shift with feedback on enable
  always_comb begin
    sig_d = sig_q;
    fb    = sig_q[15] ^ din;
    if (clr) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
    end
  end

  // MISR register
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/oai211_bist_ctrl.sv
// BIST sequencer for a single oai211 cell: sweeps all 16 input vectors,
// compares ZN to the golden function, counts and captures mismatches.
// Optional MISR signature under OAI211_BIST_SIGNATURE_EN.
module oai211_bist_ctrl
  import oai211_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int PASSES     = 1,
  parameter int ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_zn,
  output logic             dut_a1,
  output logic             dut_a2,
  output logic             dut_b,
  output logic             dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid,
  output logic [15:0]      signature
);

  localparam logic [3:0]       LAST_VEC  = 4'(VEC_N - 1);
  localparam logic [3:0]       LAST_PASS = 4'(PASSES - 1);
  localparam logic [7:0]       WAIT_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [3:0]       pass_cnt_q, pass_cnt_d;
  logic [7:0]       wait_q, wait_d;
  logic [3:0]       dut_q, dut_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       ffv_q, ffv_d;
  logic             ffvld_q, ffvld_d;

  // Next-state and result update; abort overrides everything and keeps results
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    pass_cnt_d = pass_cnt_q;
    wait_d     = wait_q;
    err_d      = err_q;
    ffv_d      = ffv_q;
    ffvld_d    = ffvld_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_APPLY;
          vec_d      = '0;
          pass_cnt_d = '0;
          err_d      = '0;
          ffv_d      = '0;
          ffvld_d    = 1'b0;
        end
      end
      ST_APPLY: begin
        state_d = ST_SETTLE;
        wait_d  = WAIT_LOAD;
      end
      ST_SETTLE: begin
        if (wait_q == 8'd0) state_d = ST_SAMPLE;
        else                wait_d  = wait_q - 8'd1;
      end
      ST_SAMPLE: begin
        if (dut_zn != oai211_golden(vec_q)) begin
          if (err_q != '1) err_d = err_q + ERR_ONE;
          if (!ffvld_q) begin
            ffv_d   = vec_q;
            ffvld_d = 1'b1;
          end
        end
        vec_d   = vec_q + 4'd1;
        state_d = ST_APPLY;
        if (vec_q == LAST_VEC) begin
          if (pass_cnt_q == LAST_PASS) state_d    = ST_DONE;
          else                         pass_cnt_d = pass_cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        // Holding start keeps us here so one request yields one run
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      vec_d      = vec_q;
      pass_cnt_d = pass_cnt_q;
      wait_d     = wait_q;
      err_d      = err_q;
      ffv_d      = ffv_q;
      ffvld_d    = ffvld_q;
    end

    // Cell inputs move only when entering APPLY; zeroed in IDLE, held otherwise
    dut_d = dut_q;
    if (state_d == ST_APPLY)     dut_d = vec_d;
    else if (state_d == ST_IDLE) dut_d = '0;
  end

  // State and result registers
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      pass_cnt_q <= '0;
      wait_q     <= '0;
      dut_q      <= '0;
      err_q      <= '0;
      ffv_q      <= '0;
      ffvld_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      pass_cnt_q <= pass_cnt_d;
      wait_q     <= wait_d;
      dut_q      <= dut_d;
      err_q      <= err_d;
      ffv_q      <= ffv_d;
      ffvld_q    <= ffvld_d;
    end
  end

  assign {dut_a1, dut_a2, dut_b, dut_c} = dut_q;
  assign busy             = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                            (state_q == ST_SAMPLE);
  assign done             = (state_q == ST_DONE);
  assign pass             = done && (err_q == '0);
  assign err_cnt          = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvld_q;

`ifdef OAI211_BIST_SIGNATURE_EN
  logic start_run, sample_en;
  assign start_run = (state_q == ST_IDLE) && start && !abort;
  assign sample_en = (state_q == ST_SAMPLE) && !abort;

  oai211_bist_misr u_misr (
    .CLK (CLK),
    .RN  (RN),
    .en  (sample_en),
    .clr (start_run),
    .din (dut_zn),
    .sig (signature)
  );
`else
  assign signature = '0;
`endif

endmodule
